// File: rtl/hazard3_bus_arbiter.sv
// hazard3_bus_arbiter
// Shares one AHB-Lite master port between the instruction fetch frontend (I)
// and the load/store unit (D). One address-phase owner is chosen per bus
// cycle; the pipelined data phase is tracked so read data, write data and
// error responses reach the requester that issued the transfer.
// D has priority; a saturating starvation counter lets I win a tie after
// I_STARVE_LIMIT consecutive D grants made while I was waiting.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   i_addr/i_size/i_addr_vld   fetch request     -> i_addr_rdy
//   i_data/i_data_vld/_err     fetch response
//   d_addr/d_size/d_write/
//   d_addr_vld                 load/store request -> d_addr_rdy
//   d_wdata                    store data, driven during D's data phase
//   d_rdata/d_data_vld/_err    load/store response
//   haddr/hwrite/hsize/htrans/
//   hwdata                     AHB-Lite master outputs
//   hready/hresp/hrdata        AHB-Lite master inputs
module hazard3_bus_arbiter #(
  parameter int W_ADDR         = 32,
  parameter int W_DATA         = 32,
  parameter int I_STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic [W_ADDR-1:0] i_addr,
  input  logic              i_size,
  input  logic              i_addr_vld,
  output logic              i_addr_rdy,
  output logic [W_DATA-1:0] i_data,
  output logic              i_data_vld,
  output logic              i_data_err,

  input  logic [W_ADDR-1:0] d_addr,
  input  logic [1:0]        d_size,
  input  logic              d_write,
  input  logic              d_addr_vld,
  output logic              d_addr_rdy,
  input  logic [W_DATA-1:0] d_wdata,
  output logic [W_DATA-1:0] d_rdata,
  output logic              d_data_vld,
  output logic              d_data_err,

  output logic [W_ADDR-1:0] haddr,
  output logic              hwrite,
  output logic [2:0]        hsize,
  output logic [1:0]        htrans,
  input  logic              hready,
  input  logic              hresp,
  output logic [W_DATA-1:0] hwdata,
  input  logic [W_DATA-1:0] hrdata
);

  // A limit of 0 needs no counter; keep a 1-bit stub tied to zero.
  localparam int CTR_W = (I_STARVE_LIMIT > 0) ? $clog2(I_STARVE_LIMIT + 1) : 1;
  localparam logic [CTR_W-1:0] STARVE_MAX = CTR_W'(I_STARVE_LIMIT);

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  localparam logic OWNER_I = 1'b0;
  localparam logic OWNER_D = 1'b1;

  // State
  logic             aph_lock_q,       aph_lock_d;
  logic             aph_lock_owner_q, aph_lock_owner_d;
  logic             dph_active_q,     dph_active_d;
  logic             dph_owner_q,      dph_owner_d;
  logic [CTR_W-1:0] starve_ctr_q,     starve_ctr_d;

  // Address-phase arbitration
  logic aph_req;   // a NONSEQ is presented this cycle
  logic owner;     // who owns it (meaningful only when aph_req)
  logic i_wins_tie;

  assign i_wins_tie = (I_STARVE_LIMIT != 0) && (starve_ctr_q == STARVE_MAX);

  always_comb begin
    aph_req = 1'b0;
    owner   = OWNER_D;
    if (aph_lock_q) begin
      // A stalled NONSEQ must be re-presented unchanged until hready.
      aph_req = 1'b1;
      owner   = aph_lock_owner_q;
    end else if (i_addr_vld && d_addr_vld) begin
      aph_req = 1'b1;
      owner   = i_wins_tie ? OWNER_I : OWNER_D;
    end else if (i_addr_vld) begin
      aph_req = 1'b1;
      owner   = OWNER_I;
    end else if (d_addr_vld) begin
      aph_req = 1'b1;
      owner   = OWNER_D;
    end
  end

  // AHB address-phase outputs
  always_comb begin
    htrans = HTRANS_IDLE;
    haddr  = '0;
    hwrite = 1'b0;
    hsize  = 3'b000;
    if (aph_req) begin
      htrans = HTRANS_NONSEQ;
      if (owner == OWNER_I) begin
        haddr = i_addr;
        hsize = i_size ? 3'b010 : 3'b001;
      end else begin
        haddr  = d_addr;
        hsize  = {1'b0, d_size};
        hwrite = d_write;
      end
    end
  end

  assign i_addr_rdy = hready && aph_req && (owner == OWNER_I);
  assign d_addr_rdy = hready && aph_req && (owner == OWNER_D);

  // Data-phase routing. A two-cycle error shows hresp with hready low first;
  // only the hready-high cycle produces a pulse.
  logic dph_done;
  assign dph_done   = dph_active_q && hready;

  assign i_data_vld = dph_done && (dph_owner_q == OWNER_I) && !hresp;
  assign i_data_err = dph_done && (dph_owner_q == OWNER_I) &&  hresp;
  assign d_data_vld = dph_done && (dph_owner_q == OWNER_D) && !hresp;
  assign d_data_err = dph_done && (dph_owner_q == OWNER_D) &&  hresp;

  assign i_data = hrdata;
  assign d_rdata = hrdata;
  // Only D ever writes, so its data bus can feed hwdata directly.
  assign hwdata = d_wdata;

  // Next-state logic
  always_comb begin
    aph_lock_d       = aph_lock_q;
    aph_lock_owner_d = aph_lock_owner_q;
    if (hready) begin
      aph_lock_d = 1'b0;
    end else if (aph_req) begin
      aph_lock_d       = 1'b1;
      aph_lock_owner_d = owner;
    end
  end

  always_comb begin
    dph_active_d = dph_active_q;
    dph_owner_d  = dph_owner_q;
    if (hready) begin
      dph_active_d = aph_req;
      dph_owner_d  = owner;
    end
  end

  always_comb begin
    starve_ctr_d = starve_ctr_q;
    if (I_STARVE_LIMIT == 0) begin
      starve_ctr_d = '0;
    end else if (i_addr_rdy || !i_addr_vld) begin
      starve_ctr_d = '0;
    end else if (d_addr_rdy) begin
      // i_addr_vld is high here: I lost the arbitration.
      starve_ctr_d = (starve_ctr_q == STARVE_MAX) ? starve_ctr_q
                                                  : starve_ctr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aph_lock_q       <= 1'b0;
      aph_lock_owner_q <= OWNER_I;
      dph_active_q     <= 1'b0;
      dph_owner_q      <= OWNER_I;
      starve_ctr_q     <= '0;
    end else begin
      aph_lock_q       <= aph_lock_d;
      aph_lock_owner_q <= aph_lock_owner_d;
      dph_active_q     <= dph_active_d;
      dph_owner_q      <= dph_owner_d;
      starve_ctr_q     <= starve_ctr_d;
    end
  end

endmodule

// File: tb/tb_hazard3_bus_arbiter.sv
// Bench for hazard3_bus_arbiter: directed vector table, hand-written
// sequences for starvation and reset, then randomized traffic checked
// against a transaction-level reference model.
module tb_hazard3_bus_arbiter;

  localparam int LIM = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] i_addr;
  logic        i_size;
  logic        i_addr_vld;
  logic        i_addr_rdy;
  logic [31:0] i_data;
  logic        i_data_vld;
  logic        i_data_err;
  logic [31:0] d_addr;
  logic [1:0]  d_size;
  logic        d_write;
  logic        d_addr_vld;
  logic        d_addr_rdy;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_data_vld;
  logic        d_data_err;
  logic [31:0] haddr;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [1:0]  htrans;
  logic        hready;
  logic        hresp;
  logic [31:0] hwdata;
  logic [31:0] hrdata;

  hazard3_bus_arbiter #(.W_ADDR(32), .W_DATA(32), .I_STARVE_LIMIT(LIM)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_addr(i_addr), .i_size(i_size), .i_addr_vld(i_addr_vld), .i_addr_rdy(i_addr_rdy),
    .i_data(i_data), .i_data_vld(i_data_vld), .i_data_err(i_data_err),
    .d_addr(d_addr), .d_size(d_size), .d_write(d_write), .d_addr_vld(d_addr_vld),
    .d_addr_rdy(d_addr_rdy), .d_wdata(d_wdata), .d_rdata(d_rdata),
    .d_data_vld(d_data_vld), .d_data_err(d_data_err),
    .haddr(haddr), .hwrite(hwrite), .hsize(hsize), .htrans(htrans),
    .hready(hready), .hresp(hresp), .hwdata(hwdata), .hrdata(hrdata)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 30) $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic drive_idle();
    i_addr = '0; i_size = 1'b0; i_addr_vld = 1'b0;
    d_addr = '0; d_size = 2'b00; d_write = 1'b0; d_addr_vld = 1'b0;
    d_wdata = '0; hready = 1'b1; hresp = 1'b0; hrdata = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    drive_idle();
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Directed vector table: one row per cycle, state carries between rows.
  typedef struct {
    logic        iv; logic [31:0] ia; logic isz;
    logic        dv; logic [31:0] da; logic [1:0] dsz; logic dw; logic [31:0] wd;
    logic        hr; logic hp; logic [31:0] rd;
    logic [1:0]  e_htrans; logic [31:0] e_haddr; logic e_hwrite; logic [2:0] e_hsize;
    logic        e_irdy, e_drdy, e_ivld, e_ierr, e_dvld, e_derr;
  } vec_t;

  vec_t tbl[16];

  // Reference model: -1 = nobody, 0 = I, 1 = D.
  int m_lock;
  int m_starve;
  int m_dph[$];

  task automatic model_reset();
    m_lock = -1; m_starve = 0; m_dph.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    //           iv ia           isz dv da           dsz dw wd            hr hp rd            htr haddr        hw hsz irdy drdy ivld ierr dvld derr
    tbl[0]  = '{1, 32'h100,      1,  0, 32'h0,       0,  0, 32'h0,        1, 0, 32'h0,        2, 32'h100,      0, 2,  1, 0, 0, 0, 0, 0};
    tbl[1]  = '{0, 32'h0,        0,  0, 32'h0,       0,  0, 32'h0,        1, 0, 32'h11111111, 0, 32'h0,        0, 0,  0, 0, 1, 0, 0, 0};
    tbl[2]  = '{0, 32'h0,        0,  0, 32'h0,       0,  0, 32'h0,        1, 0, 32'h0,        0, 32'h0,        0, 0,  0, 0, 0, 0, 0, 0};
    tbl[3]  = '{1, 32'h200,      0,  0, 32'h0,       0,  0, 32'h0,        0, 0, 32'h0,        2, 32'h200,      0, 1,  0, 0, 0, 0, 0, 0};
    tbl[4]  = '{1, 32'h200,      0,  1, 32'h300,     2,  0, 32'h0,        0, 0, 32'h0,        2, 32'h200,      0, 1,  0, 0, 0, 0, 0, 0};
    tbl[5]  = '{1, 32'h200,      0,  1, 32'h300,     2,  0, 32'h0,        0, 0, 32'h0,        2, 32'h200,      0, 1,  0, 0, 0, 0, 0, 0};
    tbl[6]  = '{1, 32'h200,      0,  1, 32'h300,     2,  0, 32'h0,        1, 0, 32'h0,        2, 32'h200,      0, 1,  1, 0, 0, 0, 0, 0};
    tbl[7]  = '{0, 32'h0,        0,  1, 32'h300,     2,  0, 32'h0,        1, 0, 32'h22222222, 2, 32'h300,      0, 2,  0, 1, 1, 0, 0, 0};
    tbl[8]  = '{0, 32'h0,        0,  0, 32'h0,       0,  0, 32'h0,        1, 0, 32'h33333333, 0, 32'h0,        0, 0,  0, 0, 0, 0, 1, 0};
    tbl[9]  = '{1, 32'h500,      1,  1, 32'h400,     2,  1, 32'h0,        1, 0, 32'h0,        2, 32'h400,      1, 2,  0, 1, 0, 0, 0, 0};
    tbl[10] = '{1, 32'h500,      1,  0, 32'h0,       0,  0, 32'hDEADBEEF, 1, 0, 32'h0,        2, 32'h500,      0, 2,  1, 0, 0, 0, 1, 0};
    tbl[11] = '{0, 32'h0,        0,  0, 32'h0,       0,  0, 32'h0,        1, 0, 32'hCAFEF00D, 0, 32'h0,        0, 0,  0, 0, 1, 0, 0, 0};
    tbl[12] = '{0, 32'h0,        0,  1, 32'h600,     2,  0, 32'h0,        1, 0, 32'h0,        2, 32'h600,      0, 2,  0, 1, 0, 0, 0, 0};
    tbl[13] = '{0, 32'h0,        0,  0, 32'h0,       0,  0, 32'h0,        0, 1, 32'h0,        0, 32'h0,        0, 0,  0, 0, 0, 0, 0, 0};
    tbl[14] = '{0, 32'h0,        0,  0, 32'h0,       0,  0, 32'h0,        1, 1, 32'h0,        0, 32'h0,        0, 0,  0, 0, 0, 0, 0, 1};
    tbl[15] = '{0, 32'h0,        0,  0, 32'h0,       0,  0, 32'h0,        1, 0, 32'h0,        0, 32'h0,        0, 0,  0, 0, 0, 0, 0, 0};

    rst_n = 1'b0;
    drive_idle();
    #1;
    chk("reset_htrans", {30'd0, htrans}, 32'd0);
    chk("reset_i_data_vld", {31'd0, i_data_vld}, 32'd0);
    chk("reset_d_data_vld", {31'd0, d_data_vld}, 32'd0);
    chk("reset_rdy", {30'd0, i_addr_rdy, d_addr_rdy}, 32'd0);
    do_reset();

    // ---- directed table ----
    for (int r = 0; r < 16; r++) begin
      if (r != 0) @(negedge clk);
      i_addr = tbl[r].ia; i_size = tbl[r].isz; i_addr_vld = tbl[r].iv;
      d_addr = tbl[r].da; d_size = tbl[r].dsz; d_write = tbl[r].dw; d_addr_vld = tbl[r].dv;
      d_wdata = tbl[r].wd; hready = tbl[r].hr; hresp = tbl[r].hp; hrdata = tbl[r].rd;
      #1;
      chk($sformatf("vec%0d_htrans", r), {30'd0, htrans}, {30'd0, tbl[r].e_htrans});
      chk($sformatf("vec%0d_haddr", r), haddr, tbl[r].e_haddr);
      chk($sformatf("vec%0d_hwrite", r), {31'd0, hwrite}, {31'd0, tbl[r].e_hwrite});
      chk($sformatf("vec%0d_hsize", r), {29'd0, hsize}, {29'd0, tbl[r].e_hsize});
      chk($sformatf("vec%0d_rdy", r), {30'd0, i_addr_rdy, d_addr_rdy},
          {30'd0, tbl[r].e_irdy, tbl[r].e_drdy});
      chk($sformatf("vec%0d_resp", r),
          {28'd0, i_data_vld, i_data_err, d_data_vld, d_data_err},
          {28'd0, tbl[r].e_ivld, tbl[r].e_ierr, tbl[r].e_dvld, tbl[r].e_derr});
      chk($sformatf("vec%0d_hwdata", r), hwdata, tbl[r].wd);
      chk($sformatf("vec%0d_i_data", r), i_data, tbl[r].rd);
      chk($sformatf("vec%0d_d_rdata", r), d_rdata, tbl[r].rd);
    end

    // ---- starvation: both requesting continuously ----
    do_reset();
    for (int c = 0; c < 10; c++) begin
      if (c != 0) @(negedge clk);
      i_addr_vld = 1'b1; i_addr = 32'h1000 + 32'(c) * 4; i_size = 1'b1;
      d_addr_vld = 1'b1; d_addr = 32'h2000 + 32'(c) * 4; d_size = 2'd2; d_write = 1'b0;
      hready = 1'b1;
      #1;
      chk($sformatf("starve_c%0d_irdy", c), {31'd0, i_addr_rdy}, (c == 4 || c == 9) ? 32'd1 : 32'd0);
      chk($sformatf("starve_c%0d_drdy", c), {31'd0, d_addr_rdy}, (c == 4 || c == 9) ? 32'd0 : 32'd1);
    end

    // ---- reset during a stalled I address phase with I data in flight ----
    do_reset();
    i_addr_vld = 1'b1; i_addr = 32'h700; i_size = 1'b1; hready = 1'b1;
    #1;
    chk("rst_seq_grant", {31'd0, i_addr_rdy}, 32'd1);
    @(negedge clk);
    i_addr = 32'h704; hready = 1'b0;
    #1;
    chk("rst_seq_stall_htrans", {30'd0, htrans}, 32'd2);
    chk("rst_seq_stall_no_pulse", {31'd0, i_data_vld}, 32'd0);
    rst_n = 1'b0; i_addr_vld = 1'b0;
    #1;
    chk("rst_seq_htrans_idle", {30'd0, htrans}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      hready = 1'b1; hresp = (c == 1);
      #1;
      chk($sformatf("rst_seq_quiet%0d", c), {30'd0, i_data_vld, i_data_err}, 32'd0);
    end
    @(negedge clk);
    hresp = 1'b0; i_addr_vld = 1'b1; i_addr = 32'h800;
    #1;
    chk("rst_seq_new_grant", {31'd0, i_addr_rdy}, 32'd1);
    @(negedge clk);
    i_addr_vld = 1'b0; hrdata = 32'h12345678;
    #1;
    chk("rst_seq_new_data", {31'd0, i_data_vld}, 32'd1);
    chk("rst_seq_new_rdata", i_data, 32'h12345678);

    // ---- randomized traffic against the reference model ----
    do_reset();
    model_reset();
    begin
      logic ipend, dpend;
      int own, dph;
      logic e_ivld, e_ierr, e_dvld, e_derr;
      logic [31:0] e_haddr;
      logic [2:0]  e_hsize;
      ipend = 1'b0; dpend = 1'b0;
      for (int c = 0; c < 3000; c++) begin
        if (c != 0) @(negedge clk);
        if (!ipend && $urandom_range(2) == 0) begin
          ipend = 1'b1; i_addr = $urandom; i_size = 1'($urandom_range(1));
        end
        if (!dpend && $urandom_range(2) == 0) begin
          dpend = 1'b1; d_addr = $urandom; d_size = 2'($urandom_range(3));
          d_write = 1'($urandom_range(1));
        end
        i_addr_vld = ipend; d_addr_vld = dpend;
        d_wdata = $urandom; hrdata = $urandom;
        hready = ($urandom_range(3) != 0);
        hresp  = ($urandom_range(5) == 0);
        #1;
        // Who should own the bus this cycle
        if (m_lock >= 0)          own = m_lock;
        else if (ipend && dpend)  own = (LIM != 0 && m_starve == LIM) ? 0 : 1;
        else if (ipend)           own = 0;
        else if (dpend)           own = 1;
        else                      own = -1;
        dph = (m_dph.size() > 0) ? m_dph[0] : -1;
        e_haddr = (own == 0) ? i_addr : (own == 1) ? d_addr : 32'h0;
        e_hsize = (own == 0) ? (i_size ? 3'd2 : 3'd1) : (own == 1) ? {1'b0, d_size} : 3'd0;
        e_ivld = hready && dph == 0 && !hresp;
        e_ierr = hready && dph == 0 &&  hresp;
        e_dvld = hready && dph == 1 && !hresp;
        e_derr = hready && dph == 1 &&  hresp;
        chk("rnd_htrans", {30'd0, htrans}, (own >= 0) ? 32'd2 : 32'd0);
        chk("rnd_haddr", haddr, e_haddr);
        chk("rnd_hsize", {29'd0, hsize}, {29'd0, e_hsize});
        chk("rnd_hwrite", {31'd0, hwrite}, (own == 1 && d_write) ? 32'd1 : 32'd0);
        chk("rnd_rdy", {30'd0, i_addr_rdy, d_addr_rdy},
            {30'd0, hready && own == 0, hready && own == 1});
        chk("rnd_resp", {28'd0, i_data_vld, i_data_err, d_data_vld, d_data_err},
            {28'd0, e_ivld, e_ierr, e_dvld, e_derr});
        chk("rnd_hwdata", hwdata, d_wdata);
        // Advance the model
        if (hready) begin
          if (m_dph.size() > 0) void'(m_dph.pop_front());
          if (own >= 0) m_dph.push_back(own);
          m_lock = -1;
        end else if (own >= 0) begin
          m_lock = own;
        end
        if (own == 1 && hready && ipend)        m_starve = (m_starve + 1 > LIM) ? LIM : m_starve + 1;
        else if ((own == 0 && hready) || !ipend) m_starve = 0;
        if (own == 0 && hready) ipend = 1'b0;
        if (own == 1 && hready) dpend = 1'b0;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
